// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers for mem_stage.
package mem_stage_pkg;

    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LD  = 6'h37;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SD  = 6'h3F;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_ACCESS2
    } mem_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == LW) || (op == LH) || (op == LD);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == SW) || (op == SH) || (op == SD);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_double(input logic [5:0] op);
        return (op == LD) || (op == SD);
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [2:0] a);
        logic m;
        m = 1'b0;
        case (op)
            LW, SW:  m = (a[1:0] != 2'b00);
            LH, SH:  m = a[0];
            LD, SD:  m = (a != 3'b000);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Ready/ack data-memory port between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-enable generation, halfword store replication and load extraction/sign-extension.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       op_i,
    input  logic             addr_hw_i,
    input  logic [WIDTH-1:0] st_data_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [3:0]       be_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] ld_data_o
);
    logic [15:0] half;

    always_comb begin
        half      = addr_hw_i ? rdata_i[WIDTH-1:WIDTH-16] : rdata_i[15:0];
        be_o      = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
        if (op_i == LH || op_i == SH) begin
            be_o = addr_hw_i ? 4'b1100 : 4'b0011;
        end
        if (op_i == SH) begin
            wdata_o = {(WIDTH/16){st_data_i[15:0]}};
        end
        if (op_i == LH) begin
            ld_data_o = {{(WIDTH-16){half[15]}}, half};
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: LW/LH/LD/SW/SH/SD over a ready/ack port, stalling upstream while busy.
// Optional MEM_ALIGN_CHECK_EN: misaligned ops pass through without a request and pulse MisalignErr.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IR_in,
    input  logic [WIDTH-3:0] PC_in,
    input  logic [WIDTH-1:0] Z_in,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic [WIDTH-1:0] Z_out,
    output logic [WIDTH-1:0] LMD,
    output logic [WIDTH-1:0] LMD_hi,
    output logic             IsStall,
    mem_stage_if.master      mem
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic             MisalignErr
`endif
);
    localparam logic [WIDTH-1:0] NOP_WORD = {NOP, {(WIDTH-6){1'b0}}};

    mem_state_e       state_q, state_d;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-3:0] pc_q;
    logic [WIDTH-1:0] z_q;

    logic [5:0]       op_in, op_q, lane_op;
    logic             lane_hw;
    logic [3:0]       lane_be;
    logic [WIDTH-1:0] lane_wdata, lane_ld;
    logic             misalign_in, start, ack;

    assign op_in = IR_in[WIDTH-1:WIDTH-6];
    assign op_q  = ir_q[WIDTH-1:WIDTH-6];
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_in = misaligned(op_in, Z_in[2:0]);
`else
    assign misalign_in = 1'b0;
`endif
    assign start = (state_q == MEM_IDLE) && is_mem_op(op_in) && !misalign_in;
    assign ack   = mem.mem_req && mem.mem_ack;

    // One aligner serves both phases: incoming op at capture, held op while accessing.
    assign lane_op = (state_q == MEM_IDLE) ? op_in : op_q;
    assign lane_hw = (state_q == MEM_IDLE) ? Z_in[1] : z_q[1];

    mem_lane_align #(.WIDTH(WIDTH)) u_lane (
        .op_i      (lane_op),
        .addr_hw_i (lane_hw),
        .st_data_i (B),
        .rdata_i   (mem.mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .ld_data_o (lane_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= MEM_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE:    if (start) state_d = MEM_ACCESS;
            MEM_ACCESS:  if (ack)   state_d = is_double(op_q) ? MEM_ACCESS2 : MEM_IDLE;
            MEM_ACCESS2: if (ack)   state_d = MEM_IDLE;
            default:                state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        IsStall = (state_q != MEM_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            IR_out        <= NOP_WORD;
            PC_out        <= '0;
            Z_out         <= '0;
            LMD           <= '0;
            LMD_hi        <= '0;
            ir_q          <= '0;
            pc_q          <= '0;
            z_q           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            MisalignErr   <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            MisalignErr <= 1'b0;
`endif
            case (state_q)
                MEM_IDLE: begin
                    LMD    <= '0;
                    LMD_hi <= '0;
                    if (start) begin
                        ir_q          <= IR_in;
                        pc_q          <= PC_in;
                        z_q           <= Z_in;
                        IR_out        <= NOP_WORD;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store(op_in);
                        mem.mem_addr  <= {Z_in[WIDTH-1:2], 2'b00};
                        mem.mem_be    <= lane_be;
                        mem.mem_wdata <= lane_wdata;
                    end else begin
                        IR_out <= IR_in;
                        PC_out <= PC_in;
                        Z_out  <= Z_in;
`ifdef MEM_ALIGN_CHECK_EN
                        MisalignErr <= misalign_in;
`endif
                    end
                end
                MEM_ACCESS: begin
                    if (ack) begin
                        if (is_load(op_q)) LMD <= lane_ld;
                        if (is_double(op_q)) begin
                            mem.mem_addr <= mem.mem_addr + WIDTH'(4);
                        end else begin
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                            IR_out      <= ir_q;
                            PC_out      <= pc_q;
                            Z_out       <= z_q;
                        end
                    end
                end
                MEM_ACCESS2: begin
                    if (ack) begin
                        if (op_q == LD) LMD_hi <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        IR_out      <= ir_q;
                        PC_out      <= pc_q;
                        Z_out       <= z_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a memory responder, plus reset/misalign sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [5:0]  ADD      = 6'h01;
    localparam logic [5:0]  UNK      = 6'h2A;
    localparam logic [31:0] NOP_WORD = {NOP, 26'h0};

    logic        clk;
    logic        rst;
    logic [31:0] IR_in, Z_in, B;
    logic [29:0] PC_in;
    logic [31:0] IR_out, Z_out, LMD, LMD_hi;
    logic [29:0] PC_out;
    logic        IsStall;
`ifdef MEM_ALIGN_CHECK_EN
    logic        MisalignErr;
`endif

    mem_stage_if #(.WIDTH(32)) mem_bus ();

    mem_stage #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .IR_in   (IR_in),
        .PC_in   (PC_in),
        .Z_in    (Z_in),
        .B       (B),
        .IR_out  (IR_out),
        .PC_out  (PC_out),
        .Z_out   (Z_out),
        .LMD     (LMD),
        .LMD_hi  (LMD_hi),
        .IsStall (IsStall),
        .mem     (mem_bus)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .MisalignErr (MisalignErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] z;
        logic [31:0] b;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int unsigned dly;
        int unsigned beats;
        logic [31:0] addr0;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] lmd;
        logic [31:0] lmd_hi;
    } vec_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] z;
        logic [31:0] lmd;
        logic [31:0] lmd_hi;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] z, input logic [31:0] b,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input int unsigned dly, input int unsigned beats,
                                input logic [31:0] addr0, input logic [3:0] be, input logic we,
                                input logic [31:0] wdata, input logic [31:0] lmd,
                                input logic [31:0] lmd_hi);
        vec_t v;
        v.op = op; v.z = z; v.b = b; v.rd0 = rd0; v.rd1 = rd1; v.dly = dly; v.beats = beats;
        v.addr0 = addr0; v.be = be; v.we = we; v.wdata = wdata; v.lmd = lmd; v.lmd_hi = lmd_hi;
        return v;
    endfunction

    // Entered and left at a negedge; the next vector is driven at once so it is captured
    // on the first edge after completion.
    task automatic run_vec(input vec_t v, input int unsigned idx);
        logic [31:0] ir;
        logic [29:0] pc;
        exp_t        e;
        int unsigned guard, stall, beats, wcnt;
        bit          in_beat, req_ok, nop_ok;
        logic [31:0] baddr[2];
        logic [31:0] bwd[2];
        logic [3:0]  bbe;
        logic        bwe;
        string       t;

        ir = {v.op, 26'(idx * 32'h111 + 32'h5)};
        pc = 30'(idx * 7 + 3);
        exp_q.push_back('{ir, pc, v.z, v.lmd, v.lmd_hi});
        IR_in = ir; PC_in = pc; Z_in = v.z; B = v.b;
        mem_bus.mem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);

        guard = 0; stall = 0; beats = 0; wcnt = 0;
        in_beat = 0; req_ok = 1; nop_ok = 1;
        baddr[0] = '0; baddr[1] = '0; bwd[0] = '0; bwd[1] = '0; bbe = '0; bwe = 1'b0;
        while (IsStall && guard < 64) begin
            guard++;
            mem_bus.mem_ack = 1'b0;
            if (!in_beat) begin
                in_beat = 1; wcnt = 0;
                if (mem_bus.mem_req !== 1'b1) req_ok = 0;
                if (beats < 2) begin
                    baddr[beats] = mem_bus.mem_addr;
                    bwd[beats]   = mem_bus.mem_wdata;
                end
                if (beats == 0) begin
                    bbe = mem_bus.mem_be;
                    bwe = mem_bus.mem_we;
                end
            end
            if (IR_out !== NOP_WORD) nop_ok = 0;
            stall++;
            wcnt++;
            if (wcnt >= v.dly) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = (beats == 0) ? v.rd0 : v.rd1;
                in_beat = 0;
                beats++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_bus.mem_ack = 1'b0;
        IR_in = NOP_WORD;

        t = $sformatf("v%0d", idx);
        e = exp_q.pop_front();
        chk({t, " bound"},   64'(guard < 64), 64'd1);
        chk({t, " IR_out"},  IR_out, e.ir);
        chk({t, " PC_out"},  PC_out, e.pc);
        chk({t, " Z_out"},   Z_out, e.z);
        chk({t, " LMD"},     LMD, e.lmd);
        chk({t, " LMD_hi"},  LMD_hi, e.lmd_hi);
        chk({t, " IsStall"}, IsStall, 1'b0);
        chk({t, " req_off"}, mem_bus.mem_req, 1'b0);
        chk({t, " stall"},   stall, v.dly * v.beats);
        chk({t, " beats"},   beats, v.beats);
        if (v.beats > 0) begin
            chk({t, " req_on"}, req_ok, 1'b1);
            chk({t, " nop"},    nop_ok, 1'b1);
            chk({t, " addr0"},  baddr[0], v.addr0);
            chk({t, " be"},     bbe, v.be);
            chk({t, " we"},     bwe, v.we);
            if (v.we) chk({t, " wdata0"}, bwd[0], v.wdata);
        end
        if (v.beats == 2) begin
            chk({t, " addr1"}, baddr[1], v.addr0 + 32'd4);
            if (v.we) chk({t, " wdata1"}, bwd[1], v.wdata);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        op   z             b             rd0           rd1           dly beats addr0        be       we    wdata         lmd           lmd_hi
        vecs.push_back(mk(ADD, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,       4'h0,    1'b0, 32'h0,        32'h0,        32'h0));
        vecs.push_back(mk(LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,       3, 1, 32'h100,     4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(LH,  32'h0000_0102, 32'h0,        32'h8001_0000, 32'h0,       1, 1, 32'h100,     4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 32'h0));
        vecs.push_back(mk(LH,  32'h0000_0104, 32'h0,        32'h1234_7FFE, 32'h0,       2, 1, 32'h104,     4'b0011, 1'b0, 32'h0,        32'h0000_7FFE, 32'h0));
        vecs.push_back(mk(SD,  32'h0000_0200, 32'h0000_55AA, 32'h0,       32'h0,        1, 2, 32'h200,     4'b1111, 1'b1, 32'h0000_55AA, 32'h0,        32'h0));
        vecs.push_back(mk(SH,  32'h0000_020E, 32'h0000_ABCD, 32'h0,       32'h0,        2, 1, 32'h20C,     4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0,        32'h0));
        vecs.push_back(mk(SW,  32'h0000_0300, 32'hA5A5_5A5A, 32'h0,       32'h0,        1, 1, 32'h300,     4'b1111, 1'b1, 32'hA5A5_5A5A, 32'h0,        32'h0));
        vecs.push_back(mk(LD,  32'h0000_0408, 32'h0,        32'hCAFE_F00D, 32'h1234_5678, 2, 2, 32'h408,   4'b1111, 1'b0, 32'h0,        32'hCAFE_F00D, 32'h1234_5678));
        vecs.push_back(mk(UNK, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,       4'h0,    1'b0, 32'h0,        32'h0,        32'h0));
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(LW,  32'h0000_010B, 32'h0,        32'h0BAD_F00D, 32'h0,       1, 1, 32'h108,     4'b1111, 1'b0, 32'h0,        32'h0BAD_F00D, 32'h0));
        vecs.push_back(mk(SH,  32'h0000_0101, 32'h1234_5678, 32'h0,       32'h0,        1, 1, 32'h100,     4'b0011, 1'b1, 32'h5678_5678, 32'h0,        32'h0));
`endif

        rst = 1'b1;
        IR_in = NOP_WORD; PC_in = '0; Z_in = '0; B = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst IR_out",  IR_out, NOP_WORD);
        chk("rst PC_out",  PC_out, 30'h0);
        chk("rst Z_out",   Z_out, 32'h0);
        chk("rst LMD",     LMD, 32'h0);
        chk("rst LMD_hi",  LMD_hi, 32'h0);
        chk("rst IsStall", IsStall, 1'b0);
        chk("rst req",     mem_bus.mem_req, 1'b0);
        chk("rst we",      mem_bus.mem_we, 1'b0);
        chk("rst addr",    mem_bus.mem_addr, 32'h0);
        chk("rst be",      mem_bus.mem_be, 4'h0);
        chk("rst wdata",   mem_bus.mem_wdata, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst MisalignErr", MisalignErr, 1'b0);
`endif

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during ACCESS abandons the load; a late ack must not revive it.
        IR_in = {LW, 26'h1}; Z_in = 32'h500; B = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rstacc req_on", mem_bus.mem_req, 1'b1);
        chk("rstacc stall_on", IsStall, 1'b1);
        IR_in = NOP_WORD;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc req_off", mem_bus.mem_req, 1'b0);
        chk("rstacc stall_off", IsStall, 1'b0);
        chk("rstacc IR_out", IR_out, NOP_WORD);
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("lateack req", mem_bus.mem_req, 1'b0);
        chk("lateack stall", IsStall, 1'b0);
        chk("lateack LMD", LMD, 32'h0);
        chk("lateack IR_out", IR_out, NOP_WORD);

`ifdef MEM_ALIGN_CHECK_EN
        IR_in = {LW, 26'h7}; Z_in = 32'h101;
        @(posedge clk);
        @(negedge clk);
        chk("mis req", mem_bus.mem_req, 1'b0);
        chk("mis stall", IsStall, 1'b0);
        chk("mis err_on", MisalignErr, 1'b1);
        chk("mis LMD", LMD, 32'h0);
        chk("mis IR_out", IR_out, {LW, 26'h7});
        chk("mis Z_out", Z_out, 32'h101);
        IR_in = NOP_WORD;
        @(posedge clk);
        @(negedge clk);
        chk("mis err_off", MisalignErr, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
